// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter in front of a single APB master port.
// Serialises NREQ local requesters into SETUP/ACCESS transfers with an optional wait-state timeout.
module apb_mst_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DW-1:0]            rsp_rdata,
  output logic                     rsp_err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [AW-1:0]            paddr,
  output logic [DW-1:0]            pwdata,
  input  logic [DW-1:0]            prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t          r_state, w_state;
  logic [GW-1:0]   r_ptr, w_ptr;
  logic [TW-1:0]   r_tcnt, w_tcnt;
  logic [GW-1:0]   w_win;
  logic            w_launch;
  logic            w_psel, w_penable, w_pwrite, w_rsp_err;
  logic [AW-1:0]   w_paddr;
  logic [DW-1:0]   w_pwdata, w_rsp_rdata;
  logic [NREQ-1:0] w_req_ready, w_rsp_valid;
  logic [GW-1:0]   w_gnt;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    w_win = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        w_win = GW'(idx);
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_tcnt      = r_tcnt;
    w_launch    = 1'b0;
    w_psel      = psel;
    w_penable   = penable;
    w_pwrite    = pwrite;
    w_paddr     = paddr;
    w_pwdata    = pwdata;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_rsp_rdata = rsp_rdata;
    w_rsp_err   = rsp_err;
    w_gnt       = grant_id;

    case (r_state)
      S_IDLE: begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_launch  = |req_valid;
      end
      S_SETUP: begin
        w_state   = S_ACCESS;
        w_penable = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          w_rsp_valid[grant_id] = 1'b1;
          w_rsp_rdata           = pwrite ? '0 : prdata;
          w_rsp_err             = pslverr;
          w_penable             = 1'b0;
          if (|req_valid) begin
            w_launch = 1'b1;
          end else begin
            w_psel  = 1'b0;
            w_state = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (int'(r_tcnt) + 1 >= TIMEOUT)) begin
          // Hung slave: abort and always pass through IDLE before the next grant.
          w_rsp_valid[grant_id] = 1'b1;
          w_rsp_rdata           = '0;
          w_rsp_err             = 1'b1;
          w_psel                = 1'b0;
          w_penable             = 1'b0;
          w_state               = S_IDLE;
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_psel    = 1'b0;
        w_penable = 1'b0;
      end
    endcase

    if (w_launch) begin
      w_state            = S_SETUP;
      w_psel             = 1'b1;
      w_penable          = 1'b0;
      w_pwrite           = req_write[w_win];
      w_paddr            = req_addr[w_win*AW +: AW];
      w_pwdata           = req_wdata[w_win*DW +: DW];
      w_req_ready[w_win] = 1'b1;
      w_gnt              = w_win;
      w_ptr              = (w_win == GW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      w_tcnt             = '0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_tcnt    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      grant_id  <= '0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_tcnt    <= w_tcnt;
      psel      <= w_psel;
      penable   <= w_penable;
      pwrite    <= w_pwrite;
      paddr     <= w_paddr;
      pwdata    <= w_pwdata;
      req_ready <= w_req_ready;
      rsp_valid <= w_rsp_valid;
      rsp_rdata <= w_rsp_rdata;
      rsp_err   <= w_rsp_err;
      grant_id  <= w_gnt;
    end
  end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed bench for apb_mst_arbiter: single transfers, wait states, contention,
// timeout abort, asynchronous reset mid-transfer and back-to-back streaming.
module tb_apb_mst_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;

  logic                pclk = 1'b0;
  logic                preset_n;
  logic [NREQ-1:0]     req_valid, req_write;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [DW-1:0]       rsp_rdata, pwdata, prdata;
  logic                rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]       paddr;
  logic [1:0]          grant_id;

  int checks = 0;
  int errors = 0;

  apb_mst_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .grant_id(grant_id)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_valid[i]            = 1'b1;
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    preset_n = 1'b1;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #2;
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite}); end
    checks++; if ({req_ready, rsp_valid} !== 8'h00) begin errors++; $display("FAIL reset_pulses: got %h expected 00", {req_ready, rsp_valid}); end
    checks++; if ({rsp_rdata, rsp_err, grant_id, paddr, pwdata} !== '0) begin errors++; $display("FAIL reset_data: got nonzero expected 0"); end
    tick(); tick();
    preset_n = 1'b1;
    tick();
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL idle_psel: got %b expected 0", psel); end
  endtask

  task automatic test_write();
    pready = 1'b1;
    set_req(0, 1'b1, 6'h14, 32'hDEADBEEF);
    tick();
    checks++; if ({psel, penable, pwrite} !== 3'b101) begin errors++; $display("FAIL wr_t1_ctrl: got %b expected 101", {psel, penable, pwrite}); end
    checks++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL wr_t1_grant: got %b/%0d expected 0001/0", req_ready, grant_id); end
    checks++; if (paddr !== 6'h14 || pwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_t1_payload: got %h/%h expected 14/deadbeef", paddr, pwdata); end
    req_valid = '0;
    tick();
    checks++; if ({psel, penable, req_ready, rsp_valid} !== 10'b11_0000_0000) begin errors++; $display("FAIL wr_t2: got %b expected 1100000000", {psel, penable, req_ready, rsp_valid}); end
    tick();
    checks++; if ({psel, penable} !== 2'b00) begin errors++; $display("FAIL wr_t3_ctrl: got %b expected 00", {psel, penable}); end
    checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_t3_rsp: got %b/%b/%h expected 0001/0/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_rsp_pulse: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    set_req(2, 1'b0, 6'h08, 32'h0);
    tick();
    checks++; if (req_ready !== 4'b0100 || grant_id !== 2'd2 || {psel, penable, pwrite} !== 3'b100) begin errors++; $display("FAIL rd_launch: got %b/%0d/%b expected 0100/2/100", req_ready, grant_id, {psel, penable, pwrite}); end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({psel, penable} !== 2'b11 || paddr !== 6'h08 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_wait%0d: got %b/%h/%b expected 11/08/0000", i, {psel, penable}, paddr, rsp_valid); end
    end
    pready = 1'b1; prdata = 32'h12345678; pslverr = 1'b1;
    tick();
    checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL rd_rsp: got %b/%h/%b/%b expected 0100/12345678/1/0", rsp_valid, rsp_rdata, rsp_err, psel); end
    pslverr = 1'b0; prdata = 32'h0;
    tick();
    checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b1) begin errors++; $display("FAIL rd_hold: got %b/%h/%b expected 0000/12345678/1", rsp_valid, rsp_rdata, rsp_err); end
  endtask

  task automatic test_contention();
    int exp_g;
    do_reset();
    pready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(6'h10 + i), 32'hA5A50000 + i);
    for (int n = 0; n < 5; n++) begin
      exp_g = n % NREQ;
      tick();
      checks++; if (grant_id !== 2'(exp_g) || req_ready !== 4'(1 << exp_g)) begin errors++; $display("FAIL cont_grant%0d: got %0d/%b expected %0d", n, grant_id, req_ready, exp_g); end
      checks++; if ({psel, penable} !== 2'b10 || paddr !== AW'(6'h10 + exp_g)) begin errors++; $display("FAIL cont_setup%0d: got %b/%h expected 10/%h", n, {psel, penable}, paddr, 6'h10 + exp_g); end
      if (n > 0) begin
        checks++; if (rsp_valid !== 4'(1 << ((n - 1) % NREQ))) begin errors++; $display("FAIL cont_rsp%0d: got %b expected requester %0d", n, rsp_valid, (n - 1) % NREQ); end
      end
      tick();
      checks++; if ({psel, penable} !== 2'b11 || req_ready !== 4'b0000) begin errors++; $display("FAIL cont_access%0d: got %b/%b expected 11/0000", n, {psel, penable}, req_ready); end
      if (n == 4) req_valid = '0;
    end
    tick();
    checks++; if (rsp_valid !== 4'b0001 || psel !== 1'b0) begin errors++; $display("FAIL cont_last: got %b/%b expected 0001/0", rsp_valid, psel); end
  endtask

  task automatic test_timeout();
    int pen_cycles;
    bit done;
    pen_cycles = 0;
    done = 1'b0;
    pready = 1'b0;
    set_req(1, 1'b1, 6'h2A, 32'h0BADF00D);
    tick();
    checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL to_launch: got %0d/%b expected 1/0010", grant_id, req_ready); end
    req_valid = '0;
    set_req(3, 1'b0, 6'h3C, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (penable) pen_cycles++;
      if (!psel) done = 1'b1;
    end
    checks++; if (!done || pen_cycles !== 16) begin errors++; $display("FAIL to_cycles: got %0d access cycles expected 16", pen_cycles); end
    checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || penable !== 1'b0) begin errors++; $display("FAIL to_rsp: got %b/%b/%h expected 0010/1/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL to_no_b2b: got %b expected 0000", req_ready); end
    tick();
    checks++; if (grant_id !== 2'd3 || req_ready !== 4'b1000 || {psel, penable} !== 2'b10) begin errors++; $display("FAIL to_next: got %0d/%b/%b expected 3/1000/10", grant_id, req_ready, {psel, penable}); end
    req_valid = '0;
    pready = 1'b1; prdata = 32'hCAFEF00D;
    tick();
    tick();
    checks++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin errors++; $display("FAIL to_next_rsp: got %b/%h/%b expected 1000/cafef00d/0", rsp_valid, rsp_rdata, rsp_err); end
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    set_req(1, 1'b0, 6'h05, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd1 || psel !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got %0d/%b expected 1/1", grant_id, psel); end
    req_valid = '0;
    tick(); tick();
    #2 preset_n = 1'b0;
    #1;
    checks++; if ({psel, penable, req_ready, rsp_valid} !== 10'b0) begin errors++; $display("FAIL rst_async: got %b expected 0", {psel, penable, req_ready, rsp_valid}); end
    tick(); tick();
    pready = 1'b1; prdata = 32'h55AA55AA;
    set_req(1, 1'b0, 6'h06, 32'h0);
    set_req(3, 1'b0, 6'h07, 32'h0);
    preset_n = 1'b1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_no_rsp: got %b expected 0000", rsp_valid); end
    tick();
    checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010 || paddr !== 6'h06) begin errors++; $display("FAIL rst_ptr: got %0d/%b/%h expected 1/0010/06", grant_id, req_ready, paddr); end
    req_valid = '0;
    tick(); tick();
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL rst_after_rsp: got %b/%h expected 0010/55aa55aa", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    pready = 1'b1;
    set_req(3, 1'b0, 6'h20, 32'h0);
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if ({psel, penable} !== 2'b10 || req_ready !== 4'b1000 || paddr !== AW'(6'h20 + n)) begin errors++; $display("FAIL b2b_setup%0d: got %b/%b/%h expected 10/1000/%h", n, {psel, penable}, req_ready, paddr, 6'h20 + n); end
      if (n > 0) begin
        if (rsp_valid === 4'b1000) pulses++;
        checks++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 32'hA0000000 + (n - 1)) begin errors++; $display("FAIL b2b_rsp%0d: got %b/%h expected 1000/%h", n, rsp_valid, rsp_rdata, 32'hA0000000 + (n - 1)); end
      end
      req_addr[3*AW +: AW] = AW'(6'h21 + n);
      tick();
      checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL b2b_access%0d: got %b expected 11", n, {psel, penable}); end
      prdata = 32'hA0000000 + n;
      if (n == 4) req_valid = '0;
    end
    tick();
    if (rsp_valid === 4'b1000) pulses++;
    checks++; if (rsp_rdata !== 32'hA0000004 || psel !== 1'b0) begin errors++; $display("FAIL b2b_last: got %h/%b expected a0000004/0", rsp_rdata, psel); end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses: got %0d expected 5", pulses); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
